// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier_pkg
// Purpose  : Shared ALU constants for the sequential shift-add multiplier:
//            operand width, iteration count and FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_pkg;

  // Operand width is fixed by the carry look-ahead adder.
  localparam int MUL_W    = 8;
  // One add-and-shift step per multiplier bit.
  localparam int MUL_ITER = 8;
  // Counter wide enough to index MUL_ITER iterations.
  localparam int CNT_W    = $clog2(MUL_ITER);

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_RUN  = 2'd1;
  localparam logic [ST_W-1:0] S_DONE = 2'd2;

endpackage : shift_add_multiplier_pkg
`default_nettype wire

// File: rtl/look_ahead_adder.sv
`default_nettype none
// ============================================================================
// Module   : look_ahead_adder
// Purpose  : W-bit carry look-ahead adder/subtractor. With cin_i=1 the
//            b operand is inverted, giving a - b.
// Ports    : a_i    [W-1:0]  first operand
//            b_i    [W-1:0]  second operand
//            cin_i           carry in / subtract select
//            sum_o  [W-1:0]  sum
//            cout_o          carry out
// Revision : 1.0 - initial release
// ============================================================================
module look_ahead_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] w_b;
  logic [W-1:0] w_gen;
  logic [W-1:0] w_prop;
  logic [W:0]   w_carry;

  assign w_b        = b_i ^ {W{cin_i}};
  assign w_gen      = a_i & w_b;
  assign w_prop     = a_i ^ w_b;
  assign w_carry[0] = cin_i;

  // Each carry is expanded directly from the generate/propagate terms of all
  // lower bits and cin, so no carry depends on another computed carry.
  for (genvar i = 0; i < W; i++) begin : g_carry
    logic w_cy;

    always_comb begin : p_cla
      logic run_p;
      w_cy  = w_gen[i];
      run_p = w_prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_cy  = w_cy | (run_p & w_gen[j]);
        run_p = run_p & w_prop[j];
      end
      w_cy = w_cy | (run_p & cin_i);
    end

    assign w_carry[i+1] = w_cy;
  end

  assign sum_o  = w_prop ^ w_carry[W-1:0];
  assign cout_o = w_carry[W];

endmodule : look_ahead_adder
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Purpose  : Sequential 8x8 -> 16-bit unsigned multiplier. One partial-product
//            add-and-shift per clock using the carry look-ahead adder; fixed
//            9-cycle latency from accepted start to done.
// Ports    : clk                 clock, rising edge
//            rst                 asynchronous active-high reset
//            start_i             request, sampled only in IDLE or DONE
//            a_i       [7:0]     multiplicand, captured on accepted start
//            b_i       [7:0]     multiplier, captured on accepted start
//            busy_o              high while computing
//            done_o              one-cycle pulse, product_o valid from here
//            product_o [15:0]    registered unsigned a*b
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [MUL_W-1:0]     a_i,
  input  logic [MUL_W-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*MUL_W-1:0]   product_o
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MUL_ITER - 1);

  logic [ST_W-1:0]    state_q,   state_d;
  logic [MUL_W-1:0]   mcand_q,   mcand_d;
  logic [MUL_W-1:0]   acc_hi_q,  acc_hi_d;
  logic [MUL_W-1:0]   acc_lo_q,  acc_lo_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*MUL_W-1:0] product_q, product_d;

  logic               w_accept;
  logic               w_last;
  logic [MUL_W-1:0]   w_sum;
  logic               w_cout;
  logic [2*MUL_W-1:0] w_shifted;

  look_ahead_adder #(
    .W (MUL_W)
  ) u_adder (
    .a_i    (acc_hi_q),
    .b_i    (mcand_q),
    .cin_i  (1'b0),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  // start is only honoured when no operation is in flight.
  assign w_accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_last   = (cnt_q == C_CNT_LAST);

  // The adder carry becomes the new MSB so operands >= 128 do not overflow
  // the 8-bit upper accumulator.
  assign w_shifted = acc_lo_q[0] ? {w_cout, w_sum, acc_lo_q[MUL_W-1:1]}
                                 : {1'b0, acc_hi_q, acc_lo_q[MUL_W-1:1]};

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (w_last)  state_d = S_DONE;
      S_DONE:  state_d = start_i ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded purely from registered state
  always_comb begin
    busy_o = (state_q == S_RUN);
    done_o = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (w_accept) begin
      mcand_d  = a_i;
      acc_hi_d = '0;
      acc_lo_d = b_i;
      cnt_d    = '0;
    end else if (state_q == S_RUN) begin
      {acc_hi_d, acc_lo_d} = w_shifted;
      cnt_d                = cnt_q + CNT_W'(1);
      if (w_last) begin
        product_d = w_shifted;
      end
    end
  end

  // Datapath registers; reset also discards any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule : shift_add_multiplier
`default_nettype wire
